multicycle_ctrl: RTL and testbench

//  Main control FSM of the multicycle datapath. Sequences instruction fetch into the instruction register,

---
 rtl/multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle datapath: fetch, decode, execute,
// memory access and writeback, with memory ready handshake and timeout.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   Opcode, Zero        IR opcode field, ALU zero flag
//   MemReady            memory completes the current access this cycle
//   IRWrite..PCSource   datapath selects and enables
//   State               current state encoding (debug)
//   Halted, BusError    in HALT / in FAULT
//   IllegalOp           sticky unknown-opcode flag, cleared by rst only
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       Halted,
    output logic       BusError,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        EXEC_I   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd12,
        FAULT    = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam bit         TMO_EN = (MEM_TIMEOUT != 0);
    localparam logic [7:0] LIMIT  = TMO_EN ? 8'(MEM_TIMEOUT - 1) : 8'd0;

    state_t     state;
    state_t     nxt;
    logic [7:0] cnt;
    logic       ill_q;
    logic       set_ill;
    logic       wait_st;
    logic       tmo;

    // States that wait on the memory handshake
    assign wait_st = (state == FETCH) || (state == MEM_RD) ||
                     (state == MEM_WR);

    // MemReady on the last allowed cycle still wins over the timeout
    assign tmo = TMO_EN && (cnt == LIMIT) && !MemReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            cnt   <= 8'd0;
            ill_q <= 1'b0;
        end else begin
            state <= nxt;
            // Any state change clears the counter, covering entry
            // into each waiting state
            if (nxt != state)
                cnt <= 8'd0;
            else if (wait_st && !MemReady && cnt != 8'hFF)
                cnt <= cnt + 8'd1;
            if (set_ill)
                ill_q <= 1'b1;
        end
    end

    always_comb begin
        nxt      = state;
        set_ill  = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSource = 2'b00;
        Halted   = 1'b0;
        BusError = 1'b0;
        unique case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = DECODE;
                end else if (tmo) begin
                    nxt = FAULT;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                unique case (Opcode)
                    OP_LW, OP_SW: nxt = MEM_ADDR;
                    OP_R:         nxt = EXEC_R;
                    OP_ADDI:      nxt = EXEC_I;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
                    OP_HALT:      nxt = HALT;
                    default: begin
                        set_ill = 1'b1;
                        nxt     = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = (Opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady)
                    nxt = MEM_WB;
                else if (tmo)
                    nxt = FAULT;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                nxt      = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady)
                    nxt = FETCH;
                else if (tmo)
                    nxt = FAULT;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nxt     = R_WB;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                nxt      = FETCH;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = I_WB;
            end
            I_WB: begin
                RegWrite = 1'b1;
                nxt      = FETCH;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                PCWrite  = Zero;
                nxt      = FETCH;
            end
            JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                nxt      = FETCH;
            end
            HALT:  Halted   = 1'b1;
            FAULT: BusError = 1'b1;
            default: nxt = FETCH;
        endcase
        // Reset masks every control output so nothing is written
        // in the reset cycle
        if (rst) begin
            nxt      = FETCH;
            set_ill  = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            IorD     = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            MemtoReg = 1'b0;
            RegDst   = 1'b0;
            RegWrite = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            ALUOp    = 2'b00;
            PCSource = 2'b00;
            Halted   = 1'b0;
            BusError = 1'b0;
        end
    end

    assign State     = state;
    assign IllegalOp = ill_q && !rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors push
// expected state/controls; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       IRWrite, PCWrite, IorD, MemRead, MemWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;
    logic       Halted, BusError, IllegalOp;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero),
        .MemReady(MemReady), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .State(State), .Halted(Halted),
        .BusError(BusError), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    // Layout: IRW PCW IorD MRd MWr M2R RDst RWr SrcA SrcB ALUOp PCSrc H B I
    localparam logic [17:0] NONE = 18'b0;
    localparam logic [17:0] FET0 = 18'b0_0_0_1_0_0_0_0_0_01_00_00_0_0_0;
    localparam logic [17:0] FET1 = 18'b1_1_0_1_0_0_0_0_0_01_00_00_0_0_0;
    localparam logic [17:0] DEC  = 18'b0_0_0_0_0_0_0_0_0_11_00_00_0_0_0;
    localparam logic [17:0] MADR = 18'b0_0_0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [17:0] MRD  = 18'b0_0_1_1_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [17:0] MWB  = 18'b0_0_0_0_0_1_0_1_0_00_00_00_0_0_0;
    localparam logic [17:0] MWR  = 18'b0_0_1_0_1_0_0_0_0_00_00_00_0_0_0;
    localparam logic [17:0] EXR  = 18'b0_0_0_0_0_0_0_0_1_00_10_00_0_0_0;
    localparam logic [17:0] RWB  = 18'b0_0_0_0_0_0_1_1_0_00_00_00_0_0_0;
    localparam logic [17:0] EXI  = 18'b0_0_0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [17:0] IWB  = 18'b0_0_0_0_0_0_0_1_0_00_00_00_0_0_0;
    localparam logic [17:0] BRZ  = 18'b0_1_0_0_0_0_0_0_1_00_01_01_0_0_0;
    localparam logic [17:0] BRN  = 18'b0_0_0_0_0_0_0_0_1_00_01_01_0_0_0;
    localparam logic [17:0] JMP  = 18'b0_1_0_0_0_0_0_0_0_00_00_10_0_0_0;
    localparam logic [17:0] HLT  = 18'b0_0_0_0_0_0_0_0_0_00_00_00_1_0_0;
    localparam logic [17:0] FLT  = 18'b0_0_0_0_0_0_0_0_0_00_00_00_0_1_0;
    localparam logic [17:0] ILL  = 18'b0_0_0_0_0_0_0_0_0_00_00_00_0_0_1;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] HLTO = 6'b111111;
    localparam logic [5:0] BAD  = 6'b011111;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [7:0]  tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [17:0] act;

    assign act = {IRWrite, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                  Halted, BusError, IllegalOp};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (State !== e.st || act !== e.ctl) begin
                n_bad++;
                $display("FAIL step%0d: state=%0d ctl=%b required state=%0d ctl=%b",
                         e.tag, State, act, e.st, e.ctl);
            end
        end
    end

    int tag = 0;

    // One cycle: drive inputs after the edge, record the expectation
    task automatic step(input logic r, input logic [5:0] op,
                        input logic z, input logic rdy,
                        input logic [3:0] st, input logic [17:0] ctl);
        rst      = r;
        Opcode   = op;
        Zero     = z;
        MemReady = rdy;
        q.push_back('{st: st, ctl: ctl, tag: 8'(tag)});
        tag++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; Opcode = R; Zero = 1'b0; MemReady = 1'b0;
        @(posedge clk);
        #1;
        step(1, R, 0, 0, 0, NONE);
        // ADDI
        step(0, ADDI, 0, 1, 0, FET1);
        step(0, ADDI, 0, 1, 1, DEC);
        step(0, ADDI, 0, 1, 8, EXI);
        step(0, ADDI, 0, 1, 9, IWB);
        // R-type
        step(0, R, 0, 1, 0, FET1);
        step(0, R, 0, 1, 1, DEC);
        step(0, R, 0, 1, 6, EXR);
        step(0, R, 0, 1, 7, RWB);
        // LW with three wait cycles in MEM_RD
        step(0, LW, 0, 1, 0, FET1);
        step(0, LW, 0, 1, 1, DEC);
        step(0, LW, 0, 1, 2, MADR);
        step(0, LW, 0, 0, 3, MRD);
        step(0, LW, 0, 0, 3, MRD);
        step(0, LW, 0, 0, 3, MRD);
        step(0, LW, 0, 1, 3, MRD);
        step(0, LW, 0, 1, 4, MWB);
        // SW
        step(0, SW, 0, 1, 0, FET1);
        step(0, SW, 0, 1, 1, DEC);
        step(0, SW, 0, 1, 2, MADR);
        step(0, SW, 0, 1, 5, MWR);
        // BEQ taken, not taken
        step(0, BEQ, 1, 1, 0, FET1);
        step(0, BEQ, 1, 1, 1, DEC);
        step(0, BEQ, 1, 1, 10, BRZ);
        step(0, BEQ, 0, 1, 0, FET1);
        step(0, BEQ, 0, 1, 1, DEC);
        step(0, BEQ, 0, 1, 10, BRN);
        // J
        step(0, J, 0, 1, 0, FET1);
        step(0, J, 0, 1, 1, DEC);
        step(0, J, 0, 1, 11, JMP);
        // Ready on the last allowed fetch cycle wins; then illegal op
        step(0, BAD, 0, 0, 0, FET0);
        step(0, BAD, 0, 0, 0, FET0);
        step(0, BAD, 0, 0, 0, FET0);
        step(0, BAD, 0, 1, 0, FET1);
        step(0, BAD, 0, 1, 1, DEC);
        // Sticky flag, then HALT absorbs
        step(0, HLTO, 0, 1, 0, FET1 | ILL);
        step(0, HLTO, 0, 1, 1, DEC | ILL);
        step(0, HLTO, 0, 1, 12, HLT | ILL);
        step(0, HLTO, 0, 1, 12, HLT | ILL);
        step(1, HLTO, 0, 1, 12, NONE);
        // Fetch timeout after four stalled cycles
        step(0, R, 0, 0, 0, FET0);
        step(0, R, 0, 0, 0, FET0);
        step(0, R, 0, 0, 0, FET0);
        step(0, R, 0, 0, 0, FET0);
        step(0, R, 0, 1, 13, FLT);
        step(0, R, 0, 1, 13, FLT);
        step(1, R, 0, 1, 13, NONE);
        // Reset mid-instruction
        step(0, R, 0, 1, 0, FET1);
        step(0, R, 0, 1, 1, DEC);
        step(1, R, 0, 1, 6, NONE);
        step(0, R, 0, 1, 0, FET1);
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++)
            @(posedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: left=%0d required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
